// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq shared definitions.
// FSM encoding and double-dabble digit constants.
package bin2bcd_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_OFFSET = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_adj3.sv
// bcd_adj3: one BCD digit correction cell.
// Adds 3 when the digit would overflow past 9 after doubling.
module bcd_adj3
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Pre-shift correction, 4-bit wrap, no carry out.
    always_comb begin
        dout = din;
        if (din >= ADD3_THRESH)
            dout = din + ADD3_OFFSET;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: serial double-dabble converter.
// One bit per clock, result and done pulse on the final shift.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    state_t              state;
    state_t              state_n;
    logic [WIDTH-1:0]    shreg;
    logic [SW-1:0]       scratch;
    logic [SW-1:0]       adj;
    logic [CW-1:0]       cnt;
    logic [SW+WIDTH-1:0] shifted;
    logic                load;
    logic                step;
    logic                last;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_adj3 u_adj (
                .din  (scratch[4*g +: 4]),
                .dout (adj[4*g +: 4])
            );
        end
    endgenerate

    assign shifted = {adj, shreg} << 1;
    assign busy    = (state == SHIFT);

    // Next state and datapath controls.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    last    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, shift/scratch datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            state <= state_n;
            done  <= last;
            if (load) begin
                shreg   <= bin;
                scratch <= '0;
                cnt     <= CW'(WIDTH);
            end else if (step) begin
                scratch <= shifted[SW+WIDTH-1:WIDTH];
                shreg   <= shifted[WIDTH-1:0];
                cnt     <= cnt - CW'(1);
            end
            if (last)
                bcd <= shifted[SW+WIDTH-1:WIDTH];
        end
    end

endmodule
